// File: rtl/ras_ctrl_pkg.sv
// Return-address-stack types: stack op encoding, controller states,
// checkpoint record and link-register helpers.
package ras_ctrl_pkg;

  // Default geometry; the checkpoint record is sized from these, so a
  // ras_ctrl instance must use matching RAS_INDEX.
  localparam int unsigned RAS_INDEX_DEF = 3;
  localparam int unsigned TAG_W_DEF     = 2;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic [1:0] {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH} ras_op_t;

  typedef enum logic {ST_IDLE, ST_RECOVER} ras_state_t;

  typedef struct packed {
    logic [RAS_INDEX_DEF-1:0] tos;
    logic [RAS_INDEX_DEF:0]   count;
    logic [31:0]              top;
  } ras_ckpt_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

endpackage

// File: rtl/rv32i_types.sv
// RV32I shared types: base opcode encodings used by decode-side consumers.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

endpackage

// File: rtl/ras_ctrl_if.sv
// Decode/execute/fetch bundle for the return-address-stack controller.
// master = pipeline side, slave = ras_ctrl.
interface ras_ctrl_if #(parameter int unsigned TAG_W = 2);
  logic             stall;
  logic             dec_valid;
  logic [6:0]       dec_opcode;
  logic [4:0]       dec_rd;
  logic [4:0]       dec_rs1;
  logic [31:0]      dec_pcp4;
  logic             dec_ckpt;
  logic [TAG_W-1:0] dec_tag;
  logic             flush;
  logic [TAG_W-1:0] flush_tag;
  logic             flush_all;
  logic [31:0]      pred_target;
  logic             pred_valid;
  logic             empty;
  logic             full;
  logic             busy;

  modport master (
    output stall, dec_valid, dec_opcode, dec_rd, dec_rs1, dec_pcp4,
           dec_ckpt, dec_tag, flush, flush_tag, flush_all,
    input  pred_target, pred_valid, empty, full, busy
  );

  modport slave (
    input  stall, dec_valid, dec_opcode, dec_rd, dec_rs1, dec_pcp4,
           dec_ckpt, dec_tag, flush, flush_tag, flush_all,
    output pred_target, pred_valid, empty, full, busy
  );
endinterface

// File: rtl/ras_ctrl_ckpt_table.sv
// Per-branch-tag checkpoint slots {tos, count, top}: one write port
// (save, cleared on reset) and one combinational read port for flush repair.
// Only built when RAS_CKPT_EN is defined.
`ifdef RAS_CKPT_EN
module ras_ckpt_table import ras_ctrl_pkg::*; #(
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  ras_ckpt_t        wr_data_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output ras_ckpt_t        rd_data_o
);
  localparam int unsigned SLOTS = 2**TAG_W;

  ras_ckpt_t slot_q [SLOTS];

  // Slot storage; a same-cycle read sees the pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
    end else if (wr_en_i) begin
      slot_q[wr_tag_i] <= wr_data_i;
    end
  end

  assign rd_data_o = slot_q[rd_tag_i];
endmodule
`endif

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: classifies jal/jalr into push/pop,
// maintains a circular stack, and repairs it after flushes.
// Build option RAS_CKPT_EN: per-tag checkpoints restored on flush; without
// it, flush empties the stack like flush_all.
module ras_ctrl import ras_ctrl_pkg::*; import rv32i_types::*; #(
  parameter int unsigned RAS_INDEX = RAS_INDEX_DEF,
  parameter int unsigned TAG_W     = TAG_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  ras_ctrl_if.slave   bus
);
  localparam int unsigned           DEPTH     = 2**RAS_INDEX;
  localparam logic [RAS_INDEX:0]    DEPTH_CNT = (RAS_INDEX+1)'(DEPTH);

  ras_state_t           state_q, state_d;
  logic [RAS_INDEX-1:0] tos_q, tos_d;
  logic [RAS_INDEX:0]   count_q, count_d;
  logic [31:0]          mem_q [DEPTH];
  logic                 mem_we;
  logic [RAS_INDEX-1:0] mem_waddr;
  logic [31:0]          mem_wdata;
  ras_op_t              op;
  logic                 idle, is_jump, op_en, wipe, restore;

  assign idle    = (state_q == ST_IDLE);
  assign is_jump = (bus.dec_opcode == op_jal) || (bus.dec_opcode == op_jalr);

`ifdef RAS_CKPT_EN
  logic      ckpt_we;
  ras_ckpt_t ckpt_wd, ckpt_rd;

  assign wipe    = bus.flush_all;
  assign restore = bus.flush & ~bus.flush_all;
  assign ckpt_we = bus.dec_ckpt & ~bus.stall & idle & ~wipe & ~restore;

  // Snapshot reflects this cycle's op, including a top write in flight.
  always_comb begin
    ckpt_wd.tos   = tos_d;
    ckpt_wd.count = count_d;
    ckpt_wd.top   = (mem_we && mem_waddr == tos_d) ? mem_wdata : mem_q[tos_d];
  end

  ras_ckpt_table #(.TAG_W(TAG_W)) u_ckpt (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (ckpt_we),
    .wr_tag_i  (bus.dec_tag),
    .wr_data_i (ckpt_wd),
    .rd_tag_i  (bus.flush_tag),
    .rd_data_o (ckpt_rd)
  );
`else
  logic unused_ckpt;

  assign wipe        = bus.flush_all | bus.flush;
  assign restore     = 1'b0;
  assign unused_ckpt = ^{bus.dec_ckpt, bus.dec_tag, bus.flush_tag};
`endif

  assign op_en = bus.dec_valid & is_jump & ~bus.stall & idle & ~wipe & ~restore;

  // Link-register classification of the decoded jump.
  always_comb begin
    op = RAS_NONE;
    if (op_en) begin
      if (is_link(bus.dec_rd) && is_link(bus.dec_rs1))
        op = (bus.dec_rd == bus.dec_rs1) ? RAS_PUSH : RAS_POPPUSH;
      else if (is_link(bus.dec_rd))
        op = RAS_PUSH;
      else if (is_link(bus.dec_rs1))
        op = RAS_POP;
    end
  end

  // Next pointer/count/state and the single stack write port.
  always_comb begin
    state_d   = state_q;
    tos_d     = tos_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = tos_q;
    mem_wdata = bus.dec_pcp4;
    if (wipe) begin
      tos_d   = '0;
      count_d = '0;
      state_d = ST_RECOVER;
    end
`ifdef RAS_CKPT_EN
    else if (restore) begin
      tos_d     = ckpt_rd.tos;
      count_d   = ckpt_rd.count;
      mem_we    = 1'b1;
      mem_waddr = ckpt_rd.tos;
      mem_wdata = ckpt_rd.top;
      state_d   = ST_RECOVER;
    end
`endif
    else begin
      state_d = ST_IDLE;
      // An empty-stack POPPUSH has nothing to replace, so it pushes.
      if (op == RAS_PUSH || (op == RAS_POPPUSH && count_q == '0)) begin
        tos_d     = tos_q + 1'b1;
        mem_we    = 1'b1;
        mem_waddr = tos_q + 1'b1;
        count_d   = (count_q == DEPTH_CNT) ? count_q : count_q + 1'b1;
      end else if (op == RAS_POPPUSH) begin
        mem_we = 1'b1;
      end else if (op == RAS_POP && count_q != '0) begin
        tos_d   = tos_q - 1'b1;
        count_d = count_q - 1'b1;
      end
    end
  end

  // Controller state, stack pointer and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tos_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      count_q <= count_d;
    end
  end

  // Stack storage is deliberately not reset; pred_valid gates its use.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.pred_target = mem_q[tos_q];
  assign bus.pred_valid  = (count_q != '0) & idle;
  assign bus.empty       = (count_q == '0);
  assign bus.full        = (count_q == DEPTH_CNT);
  assign bus.busy        = (state_q == ST_RECOVER);
endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: vector table with expected outputs fed
// through a scoreboard queue, plus reset-during-recover sequence.
module tb_ras_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ras_ctrl_if #(.TAG_W(2)) bus ();
  ras_ctrl #(.RAS_INDEX(3), .TAG_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [6:0] J  = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111;

  typedef struct {
    logic v; logic [6:0] opc; logic [4:0] rd; logic [4:0] rs1; logic [31:0] pcp4;
    logic ck; logic [1:0] tag; logic fl; logic [1:0] ftag; logic fa; logic st;
  } stim_t;
  typedef struct { logic [31:0] tgt; logic pv; logic emp; logic ful; logic bsy; } exp_t;
  typedef struct { stim_t s; exp_t e; } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  function automatic stim_t S(logic v, logic [6:0] opc, logic [4:0] rd, logic [4:0] rs1,
                              logic [31:0] pcp4, logic ck, logic [1:0] tag, logic fl,
                              logic [1:0] ftag, logic fa, logic st);
    stim_t s;
    s.v = v; s.opc = opc; s.rd = rd; s.rs1 = rs1; s.pcp4 = pcp4; s.ck = ck;
    s.tag = tag; s.fl = fl; s.ftag = ftag; s.fa = fa; s.st = st;
    return s;
  endfunction

  function automatic stim_t PUSH(logic [31:0] p); return S(1, J, 5'd1, 5'd0, p, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t POP();  return S(1, JR, 5'd0, 5'd1, 32'h0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t NOP();  return S(0, 7'h0, 5'd0, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t FL(logic [1:0] t); return S(0, 7'h0, 5'd0, 5'd0, 32'h0, 0, 0, 1, t, 0, 0); endfunction

  function automatic exp_t E(logic [31:0] tgt, logic pv, logic emp, logic ful, logic bsy);
    exp_t e;
    e.tgt = tgt; e.pv = pv; e.emp = emp; e.ful = ful; e.bsy = bsy;
    return e;
  endfunction

  function automatic vec_t V(stim_t s, exp_t e);
    vec_t x;
    x.s = s; x.e = e;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic drive(input stim_t s);
    bus.dec_valid = s.v;  bus.dec_opcode = s.opc; bus.dec_rd = s.rd; bus.dec_rs1 = s.rs1;
    bus.dec_pcp4 = s.pcp4; bus.dec_ckpt = s.ck; bus.dec_tag = s.tag;
    bus.flush = s.fl; bus.flush_tag = s.ftag; bus.flush_all = s.fa; bus.stall = s.st;
  endtask

  task automatic compare(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({nm, ".busy"},  {31'd0, bus.busy},       {31'd0, e.bsy});
      chk({nm, ".pv"},    {31'd0, bus.pred_valid}, {31'd0, e.pv});
      chk({nm, ".empty"}, {31'd0, bus.empty},      {31'd0, e.emp});
      chk({nm, ".full"},  {31'd0, bus.full},       {31'd0, e.ful});
      if (!e.emp) chk({nm, ".target"}, bus.pred_target, e.tgt);
    end
  endtask

  task automatic apply(input vec_t x, input string nm);
    @(negedge clk);
    drive(x.s);
    sb.push_back(x.e);
    @(posedge clk);
    #1;
    compare(nm);
  endtask

  initial begin
    rst = 1'b1;
    drive(NOP());

    // Common sequence: basic push, wrap to full, drain, op classification.
    tbl.push_back(V(PUSH(32'h100), E(32'h100, 1, 0, 0, 0)));
    tbl.push_back(V(S(0, 7'h0, 5'd0, 5'd0, 32'h0, 0, 0, 0, 0, 1, 0), E(0, 0, 1, 0, 1)));
    tbl.push_back(V(NOP(), E(0, 0, 1, 0, 0)));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(V(PUSH(32'(k * 16)), E(32'(k * 16), 1, 0, (k >= 8), 0)));
    for (int i = 1; i <= 7; i++)
      tbl.push_back(V(POP(), E(32'(144 - 16 * i), 1, 0, 0, 0)));
    tbl.push_back(V(POP(), E(0, 0, 1, 0, 0)));
    tbl.push_back(V(POP(), E(0, 0, 1, 0, 0)));
    tbl.push_back(V(S(1, J, 5'd1, 5'd0, 32'h555, 1, 1, 0, 0, 0, 1), E(0, 0, 1, 0, 0)));
    tbl.push_back(V(S(1, JR, 5'd5, 5'd1, 32'h200, 0, 0, 0, 0, 0, 0), E(32'h200, 1, 0, 0, 0)));
    tbl.push_back(V(S(1, JR, 5'd5, 5'd1, 32'h300, 0, 0, 0, 0, 0, 0), E(32'h300, 1, 0, 0, 0)));
    tbl.push_back(V(POP(), E(0, 0, 1, 0, 0)));
    tbl.push_back(V(S(1, JR, 5'd1, 5'd1, 32'h400, 0, 0, 0, 0, 0, 0), E(32'h400, 1, 0, 0, 0)));
    tbl.push_back(V(S(1, JR, 5'd5, 5'd5, 32'h404, 0, 0, 0, 0, 0, 0), E(32'h404, 1, 0, 0, 0)));
    tbl.push_back(V(POP(), E(32'h400, 1, 0, 0, 0)));
    tbl.push_back(V(S(1, J, 5'd0, 5'd0, 32'h999, 0, 0, 0, 0, 0, 0), E(32'h400, 1, 0, 0, 0)));
    tbl.push_back(V(S(1, 7'h33, 5'd1, 5'd0, 32'h998, 0, 0, 0, 0, 0, 0), E(32'h400, 1, 0, 0, 0)));
    tbl.push_back(V(S(0, J, 5'd1, 5'd0, 32'h997, 0, 0, 0, 0, 0, 0), E(32'h400, 1, 0, 0, 0)));
    tbl.push_back(V(S(1, J, 5'd5, 5'd0, 32'h500, 0, 0, 0, 0, 0, 0), E(32'h500, 1, 0, 0, 0)));
    tbl.push_back(V(POP(), E(32'h400, 1, 0, 0, 0)));
    tbl.push_back(V(S(1, J, 5'd1, 5'd0, 32'h777, 0, 0, 1, 0, 1, 0), E(0, 0, 1, 0, 1)));
    tbl.push_back(V(PUSH(32'h888), E(0, 0, 1, 0, 0)));
    tbl.push_back(V(PUSH(32'h123), E(32'h123, 1, 0, 0, 0)));
`ifdef RAS_CKPT_EN
    tbl.push_back(V(S(1, J, 5'd1, 5'd0, 32'hA0, 1, 2, 0, 0, 0, 0), E(32'hA0, 1, 0, 0, 0)));
    tbl.push_back(V(POP(), E(32'h123, 1, 0, 0, 0)));
    tbl.push_back(V(PUSH(32'hB0), E(32'hB0, 1, 0, 0, 0)));
    tbl.push_back(V(PUSH(32'hB0), E(32'hB0, 1, 0, 0, 0)));
    tbl.push_back(V(S(1, J, 5'd1, 5'd0, 32'hEE, 1, 2, 1, 2, 0, 0), E(32'hA0, 0, 0, 0, 1)));
    tbl.push_back(V(NOP(), E(32'hA0, 1, 0, 0, 0)));
    tbl.push_back(V(POP(), E(32'h123, 1, 0, 0, 0)));
    tbl.push_back(V(POP(), E(0, 0, 1, 0, 0)));
    tbl.push_back(V(PUSH(32'hC0), E(32'hC0, 1, 0, 0, 0)));
    tbl.push_back(V(FL(2'd3), E(0, 0, 1, 0, 1)));
    tbl.push_back(V(FL(2'd2), E(32'hA0, 0, 0, 0, 1)));
    tbl.push_back(V(NOP(), E(32'hA0, 1, 0, 0, 0)));
    tbl.push_back(V(S(1, J, 5'd1, 5'd0, 32'hDD, 1, 2, 0, 0, 0, 1), E(32'hA0, 1, 0, 0, 0)));
    tbl.push_back(V(POP(), E(32'hC0, 1, 0, 0, 0)));
    tbl.push_back(V(FL(2'd2), E(32'hA0, 0, 0, 0, 1)));
    tbl.push_back(V(NOP(), E(32'hA0, 1, 0, 0, 0)));
    tbl.push_back(V(POP(), E(32'hC0, 1, 0, 0, 0)));
    tbl.push_back(V(POP(), E(0, 0, 1, 0, 0)));
`else
    tbl.push_back(V(S(1, J, 5'd1, 5'd0, 32'h55, 1, 2, 0, 0, 0, 0), E(32'h55, 1, 0, 0, 0)));
    tbl.push_back(V(S(1, J, 5'd1, 5'd0, 32'h66, 0, 0, 1, 2, 0, 0), E(0, 0, 1, 0, 1)));
    tbl.push_back(V(PUSH(32'h77), E(0, 0, 1, 0, 0)));
    tbl.push_back(V(PUSH(32'h88), E(32'h88, 1, 0, 0, 0)));
    tbl.push_back(V(FL(2'd1), E(0, 0, 1, 0, 1)));
    tbl.push_back(V(FL(2'd1), E(0, 0, 1, 0, 1)));
    tbl.push_back(V(NOP(), E(0, 0, 1, 0, 0)));
    tbl.push_back(V(PUSH(32'h99), E(32'h99, 1, 0, 0, 0)));
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    sb.push_back(E(0, 0, 1, 0, 0));
    compare("reset");

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Enter RECOVER, then pulse rst before the next edge.
`ifdef RAS_CKPT_EN
    apply(V(FL(2'd2), E(32'hA0, 0, 0, 0, 1)), "rec_enter");
`else
    apply(V(FL(2'd2), E(0, 0, 1, 0, 1)), "rec_enter");
`endif
    #2;
    rst = 1'b1;
    #1;
    sb.push_back(E(0, 0, 1, 0, 0));
    compare("rst_mid_recover");
    @(negedge clk);
    drive(NOP());
    rst = 1'b0;
    apply(V(FL(2'd2), E(0, 0, 1, 0, 1)), "post_rst_flush");
    apply(V(PUSH(32'hAB), E(0, 0, 1, 0, 0)), "post_rst_recover_push");
    apply(V(PUSH(32'hAB), E(32'hAB, 1, 0, 0, 0)), "post_rst_push");

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Controller for the return-address stack in the branch-prediction unit. Classifies decoded jal/jalr instructions into push/pop operations and sequences a circular return-address store. Checkpoints the stack pointer and top entry per in-flight branch tag, and repairs the stack in one cycle on a misprediction flush. Sits between decode/execute (classification, checkpoints, flushes) and fetch (target prediction).

## Interface
Parameters:
- RAS_INDEX, 3, log2 of stack depth (DEPTH = 2**RAS_INDEX entries)
- TAG_W, 2, branch-tag width (2**TAG_W checkpoint slots)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  pipeline stall; blocks push/pop and checkpoint save
- dec_valid  in  1  decoded instruction valid
- dec_opcode  in  7  rv32i opcode
- dec_rd  in  5  destination register
- dec_rs1  in  5  source register 1
- dec_pcp4  in  32  PC+4 of the instruction (push value)
- dec_ckpt  in  1  save checkpoint for this instruction
- dec_tag  in  TAG_W  checkpoint slot to write
- flush  in  1  misprediction; restore from flush_tag
- flush_tag  in  TAG_W  slot to restore
- flush_all  in  1  exception/trap; empty the stack
- pred_target  out  32  current top-of-stack address
- pred_valid  out  1  pred_target usable (count != 0 and state IDLE)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- busy  out  1  high in RECOVER

## Operation
- Link register: x1 or x5. Op is computed only when dec_valid, opcode is op_jal or op_jalr, ~stall, and state is IDLE.
- Op selection:
  - rd link, rs1 not: PUSH.
  - rs1 link, rd not: POP.
  - Both link, rd==rs1: PUSH.
  - Both link, rd!=rs1: POPPUSH (top overwritten with dec_pcp4; pointer and count unchanged).
  - Neither link: NONE.
- PUSH:
  - tos <= tos+1 mod DEPTH; mem[tos+1] <= dec_pcp4.
  - count saturates at DEPTH. On full, the push overwrites the oldest entry (wrap-around).
- POP: tos <= tos-1 mod DEPTH; count decrements.
- POP on empty: no pointer or count change.
- POPPUSH on empty: behaves as PUSH.
- Checkpoint: on dec_ckpt & ~stall & IDLE, slot[dec_tag] <= {tos, count, top value} as they are after this cycle's op.
- flush, from any state:
  - Loads tos and count from slot[flush_tag] and writes the saved top value into mem[saved tos].
  - Any same-cycle op or checkpoint is discarded.
  - State goes to RECOVER.
- flush_all: tos <= 0, count <= 0; same-cycle flush and ops are discarded; state goes to RECOVER. Priority: flush_all > flush > decode op.
- FSM:
  - IDLE: on flush or flush_all, go to RECOVER.
  - RECOVER (exactly one cycle): busy=1, pred_valid=0, decode ops and checkpoints ignored; then IDLE. A flush arriving in RECOVER restarts RECOVER.
- pred_target = mem[tos], read combinationally from registered state.

## Timing
- Reset values:
  - tos=0, count=0, state IDLE; all checkpoint slots {0,0,0}.
  - pred_target=mem[0]; memory is not reset.
  - pred_valid=0, empty=1, full=0, busy=0.
- Push/pop latency: the updated pred_target and flags are visible in the cycle after the edge that samples the op.
- Flush latency:
  - Restored state is visible the cycle after flush is sampled, with busy=1.
  - pred_valid returns one cycle later (IDLE), provided the restored count != 0.
- A checkpoint saved and flushed to the same tag in the same cycle: the flush uses the old slot contents.
- rst asserted mid-RECOVER: immediate return to reset values.

## Configuration
- RAS_CKPT_EN defined: checkpoint table present; flush restores as above.
- RAS_CKPT_EN undefined:
  - No checkpoint storage; dec_ckpt, dec_tag and flush_tag are ignored.
  - flush behaves exactly as flush_all (stack emptied, RECOVER entered).

## Structure
- types package:
  - ras_op_t enum {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH}
  - ras_ckpt_t struct {tos, count, top}
  - link-register constants 5'd1, 5'd5
- rv32i_types supplies op_jal/op_jalr.
- One sub-module, ras_ckpt_table: slot array with one write port (save/reset) and one combinational read port (flush_tag). Compiled only under RAS_CKPT_EN.

## Test plan
- Reset, then jal rd=x1 with pcp4=0x100 → next cycle pred_target=0x100, pred_valid=1, empty=0.
- 9 pushes 0x10..0x90 with RAS_INDEX=3 → full=1, count=8. Then 8 pops yield 0x90 down to 0x20, then empty=1. A 9th pop changes nothing.
- jalr rd=x5, rs1=x1 with top 0x200 and pcp4=0x300 → pred_target=0x300, count unchanged. jalr rd=x1, rs1=x1 → PUSH.
- Push 0xA0 with dec_ckpt tag=2; then pop, and push 0xB0 twice; then flush tag=2 → next cycle busy=1, pred_target=0xA0. The following cycle pred_valid=1 and the count equals the count saved with the checkpoint.
- flush_all together with flush and a push → stack empty, RECOVER one cycle, push ignored. Without RAS_CKPT_EN, flush alone gives the same result.
- stall high with jal rd=x1 and dec_ckpt → no pointer or slot change. Async rst pulse during RECOVER → all outputs at reset values before the next edge.
